// File: rtl/gen_regbank.sv
// gen_regbank: bank of NUM_REGS registers, each bus_width+1 bits, behind a
// shared active-low read/write strobe pair. Each register is RW or sticky
// W1C status (selected by W1C_MASK). The W1C registers feed an aggregated irq.
// Every register is also exported in parallel on reg_q.
// Optional macro GEN_REGBANK_LOCK_EN adds a 'lock' input that blocks RW writes.

// One register slot. It holds either an RW register or a W1C status register.
module gen_regbank_reg #(
    parameter int                 bus_width = 15,
    parameter bit                 IS_W1C    = 1'b0,
    parameter logic [bus_width:0] RESET_VAL = '0
) (
    input  logic               sysclk,
    input  logic               reset,
    input  logic               i_wr,
    input  logic [bus_width:0] i_din,
    input  logic [bus_width:0] i_evt,
    output logic [bus_width:0] o_q
);

    logic [bus_width:0] r_q;
    logic [bus_width:0] w_clr;
    logic [bus_width:0] w_set;

    // Both flavours use the same update form: next = (q & ~clr) | set.
    // RW: a write clears everything and sets din.
    // W1C: a write clears the 1-bits of din, and events set bits. Set is
    // applied last, so an event beats a clear on the same bit.
    assign w_clr = i_wr ? (IS_W1C ? i_din : '1) : '0;
    assign w_set = IS_W1C ? i_evt : (i_wr ? i_din : '0);

    // Register state; W1C slots always come out of reset cleared
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) r_q <= IS_W1C ? '0 : RESET_VAL;
        else        r_q <= (r_q & ~w_clr) | w_set;
    end

    assign o_q = r_q;

endmodule

module gen_regbank #(
    parameter int                  bus_width  = 15,
    parameter int                  NUM_REGS   = 4,
    parameter int                  ADDR_WIDTH = 2,
    parameter logic [NUM_REGS-1:0] W1C_MASK   = 4'b1000,
    parameter logic [bus_width:0]  RESET_VAL  = '0
) (
    input  logic                              sysclk,
    input  logic                              reset,
`ifdef GEN_REGBANK_LOCK_EN
    input  logic                              lock,
`endif
    input  logic                              wrb,
    input  logic                              rdb,
    input  logic [ADDR_WIDTH-1:0]             addr,
    input  logic [bus_width:0]                din,
    input  logic [NUM_REGS*(bus_width+1)-1:0] evt,
    output logic [bus_width:0]                rdout,
    output logic                              rvalid,
    output logic                              addr_err,
    output logic                              irq,
    output logic [NUM_REGS*(bus_width+1)-1:0] reg_q
);

    logic [NUM_REGS-1:0][bus_width:0] w_q;
    logic [NUM_REGS-1:0][bus_width:0] w_evt;
    logic [NUM_REGS-1:0]              w_sel;
    logic [NUM_REGS-1:0]              w_wr_en;
    logic [NUM_REGS-1:0]              w_irq_src;
    logic [31:0]                      w_addr32;
    logic                             w_in_range;
    logic                             w_lock;
    logic                             w_blocked;
    logic                             w_err;
    logic [bus_width:0]               w_rd_data;

    logic [bus_width:0]               r_rdout;
    logic                             r_rvalid;
    logic                             r_addr_err;
    logic                             r_irq;

`ifdef GEN_REGBANK_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    // Widen the address once so range and select compares are width-clean.
    assign w_addr32   = 32'(addr);
    assign w_in_range = w_addr32 < 32'(NUM_REGS);
    assign w_evt      = evt;

    genvar i;
    generate
        for (i = 0; i < NUM_REGS; i++) begin : g_reg
            assign w_sel[i]     = (w_addr32 == 32'(i));
            // Lock blocks only RW slots. W1C clears always go through.
            assign w_wr_en[i]   = !wrb && w_sel[i] && (W1C_MASK[i] || !w_lock);
            assign w_irq_src[i] = W1C_MASK[i] && (|w_q[i]);

            gen_regbank_reg #(
                .bus_width (bus_width),
                .IS_W1C    (W1C_MASK[i]),
                .RESET_VAL (RESET_VAL)
            ) u_reg (
                .sysclk (sysclk),
                .reset  (reset),
                .i_wr   (w_wr_en[i]),
                .i_din  (din),
                .i_evt  (w_evt[i]),
                .o_q    (w_q[i])
            );
        end
    endgenerate

    // A write that was addressed to an RW slot while locked is reported like an out-of-range access.
    assign w_blocked = !wrb && w_lock && (|(w_sel & ~W1C_MASK));
    assign w_err     = (!w_in_range && (!wrb || !rdb)) || w_blocked;

    // Read mux. An out-of-range address selects nothing, so it reads 0.
    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_sel[k]) w_rd_data = w_q[k];
        end
    end

    // Registered read port, error pulse and interrupt.
    // The read mux sees pre-write state, so a simultaneous read and write returns the old value.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_rdout    <= '0;
            r_rvalid   <= 1'b0;
            r_addr_err <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (!rdb) r_rdout <= w_rd_data;
            r_rvalid   <= !rdb;
            r_addr_err <= w_err;
            r_irq      <= |w_irq_src;
        end
    end

    assign rdout    = r_rdout;
    assign rvalid   = r_rvalid;
    assign addr_err = r_addr_err;
    assign irq      = r_irq;
    assign reg_q    = w_q;

endmodule

// File: tb/tb_gen_regbank.sv
// Self-checking bench for gen_regbank. A 4-register default instance is used for the main
// function. A 3-register instance is used for out-of-range accesses. Read results are
// checked through per-instance scoreboards.
module tb_gen_regbank;

    logic              sysclk;
    logic              reset;
    logic              wrb, rdb;
    logic [1:0]        addr;
    logic [15:0]       din;
    logic [3:0][15:0]  evt;
    logic [15:0]       rdout;
    logic              rvalid, addr_err, irq;
    logic [3:0][15:0]  reg_q;

    logic              wrb3, rdb3;
    logic [1:0]        addr3;
    logic [15:0]       din3;
    logic [2:0][15:0]  evt3;
    logic [15:0]       rdout3;
    logic              rvalid3, addr_err3, irq3;
    logic [2:0][15:0]  reg_q3;
`ifdef GEN_REGBANK_LOCK_EN
    logic              lock, lock3;
`endif

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_q3[$];

    gen_regbank u_dut (
        .sysclk(sysclk), .reset(reset),
`ifdef GEN_REGBANK_LOCK_EN
        .lock(lock),
`endif
        .wrb(wrb), .rdb(rdb), .addr(addr), .din(din), .evt(evt),
        .rdout(rdout), .rvalid(rvalid), .addr_err(addr_err), .irq(irq), .reg_q(reg_q)
    );

    gen_regbank #(.NUM_REGS(3), .ADDR_WIDTH(2), .W1C_MASK(3'b100)) u_dut3 (
        .sysclk(sysclk), .reset(reset),
`ifdef GEN_REGBANK_LOCK_EN
        .lock(lock3),
`endif
        .wrb(wrb3), .rdb(rdb3), .addr(addr3), .din(din3), .evt(evt3),
        .rdout(rdout3), .rvalid(rvalid3), .addr_err(addr_err3), .irq(irq3), .reg_q(reg_q3)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Scoreboard: every rvalid pops one expected read result
    always @(negedge sysclk) begin
        if (reset && rvalid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rd_unexpected: rdout=%h with no read pending", rdout);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (rdout !== e) begin
                    failures++;
                    $display("FAIL rd_data: got %h expected %h", rdout, e);
                end
            end
        end
    end

    // Scoreboard for the 3-register instance
    always @(negedge sysclk) begin
        if (reset && rvalid3) begin
            checks++;
            if (exp_q3.size() == 0) begin
                failures++;
                $display("FAIL rd3_unexpected: rdout=%h with no read pending", rdout3);
            end else begin
                logic [15:0] e;
                e = exp_q3.pop_front();
                if (rdout3 !== e) begin
                    failures++;
                    $display("FAIL rd3_data: got %h expected %h", rdout3, e);
                end
            end
        end
    end

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        @(negedge sysclk); wrb = 1'b0; addr = a; din = d;
        @(negedge sysclk); wrb = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [15:0] e);
        @(negedge sysclk); rdb = 1'b0; addr = a; exp_q.push_back(e);
        @(negedge sysclk); rdb = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; wrb = 1'b1; rdb = 1'b1; addr = '0; din = '0; evt = '0;
        wrb3 = 1'b1; rdb3 = 1'b1; addr3 = '0; din3 = '0; evt3 = '0;
`ifdef GEN_REGBANK_LOCK_EN
        lock = 1'b0; lock3 = 1'b0;
`endif
        repeat (2) @(negedge sysclk);
        checks++;
        if (rdout !== 16'h0 || rvalid !== 1'b0 || addr_err !== 1'b0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: rdout=%h rvalid=%b err=%b irq=%b expected 0", rdout, rvalid, addr_err, irq);
        end
        checks++;
        if (reg_q !== 64'h0) begin
            failures++;
            $display("FAIL reset_regs: reg_q=%h expected 0", reg_q);
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge sysclk);
            if (i == 1) begin
                checks++;
                if (rvalid !== 1'b1) begin
                    failures++;
                    $display("FAIL rd_latency: rvalid=%b expected 1", rvalid);
                end
            end
            rdb = 1'b0; addr = 2'(i); exp_q.push_back(16'h0000);
        end
        @(negedge sysclk); rdb = 1'b1;
        @(negedge sysclk);
        checks++;
        if (rvalid !== 1'b0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: rvalid=%b irq=%b expected 0 0", rvalid, irq);
        end
    endtask

    task automatic test_rw();
        wr(2'd1, 16'hA5C3);
        checks++;
        if (reg_q[1] !== 16'hA5C3 || reg_q[0] !== 16'h0 || addr_err !== 1'b0) begin
            failures++;
            $display("FAIL rw_write: reg1=%h reg0=%h err=%b expected a5c3 0000 0", reg_q[1], reg_q[0], addr_err);
        end
        rd(2'd1, 16'hA5C3);
        // event bits on an RW slot have no effect
        @(negedge sysclk); evt[0] = 16'hFFFF;
        @(negedge sysclk); evt = '0;
        checks++;
        if (reg_q[0] !== 16'h0) begin
            failures++;
            $display("FAIL rw_evt_ignored: reg0=%h expected 0000", reg_q[0]);
        end
    endtask

    task automatic test_w1c();
        @(negedge sysclk); evt[3] = 16'h0011;
        @(negedge sysclk); evt = '0;
        checks++;
        if (reg_q[3] !== 16'h0011 || irq !== 1'b0) begin
            failures++;
            $display("FAIL w1c_set: reg3=%h irq=%b expected 0011 0", reg_q[3], irq);
        end
        @(negedge sysclk);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL w1c_irq_rise: irq=%b expected 1", irq);
        end
        wr(2'd3, 16'h0001);
        checks++;
        if (reg_q[3] !== 16'h0010 || irq !== 1'b1) begin
            failures++;
            $display("FAIL w1c_clear1: reg3=%h irq=%b expected 0010 1", reg_q[3], irq);
        end
        wr(2'd3, 16'h0010);
        checks++;
        if (reg_q[3] !== 16'h0000 || irq !== 1'b1) begin
            failures++;
            $display("FAIL w1c_clear2: reg3=%h irq=%b expected 0000 1", reg_q[3], irq);
        end
        @(negedge sysclk);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL w1c_irq_fall: irq=%b expected 0", irq);
        end
        rd(2'd3, 16'h0000);
    endtask

    task automatic test_set_wins();
        @(negedge sysclk); evt[3] = 16'h0004;
        @(negedge sysclk); evt[3] = 16'h0004; wrb = 1'b0; addr = 2'd3; din = 16'h0004;
        @(negedge sysclk); evt = '0; wrb = 1'b1;
        checks++;
        if (reg_q[3] !== 16'h0004) begin
            failures++;
            $display("FAIL set_wins: reg3=%h expected 0004", reg_q[3]);
        end
        // clearing one bit while a different bit is set
        @(negedge sysclk); evt[3] = 16'h0001; wrb = 1'b0; addr = 2'd3; din = 16'h0004;
        @(negedge sysclk); evt = '0; wrb = 1'b1;
        checks++;
        if (reg_q[3] !== 16'h0001) begin
            failures++;
            $display("FAIL set_clr_mix: reg3=%h expected 0001", reg_q[3]);
        end
        wr(2'd3, 16'hFFFF);
        repeat (2) @(negedge sysclk);
        checks++;
        if (reg_q[3] !== 16'h0 || irq !== 1'b0) begin
            failures++;
            $display("FAIL w1c_clear_all: reg3=%h irq=%b expected 0000 0", reg_q[3], irq);
        end
    endtask

    task automatic test_rw_collision();
        wr(2'd2, 16'h1234);
        @(negedge sysclk); wrb = 1'b0; rdb = 1'b0; addr = 2'd2; din = 16'hBEEF;
        exp_q.push_back(16'h1234);
        @(negedge sysclk); wrb = 1'b1; rdb = 1'b1;
        checks++;
        if (reg_q[2] !== 16'hBEEF) begin
            failures++;
            $display("FAIL collision_write: reg2=%h expected beef", reg_q[2]);
        end
        rd(2'd2, 16'hBEEF);
    endtask

    task automatic test_back_to_back();
        logic [1:0] seq [5];
        logic [15:0] val [4];
        seq = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd2};
        val = '{16'h1111, 16'h2222, 16'h3333, 16'h0808};
        wr(2'd0, 16'h1111);
        wr(2'd1, 16'h2222);
        wr(2'd2, 16'h3333);
        @(negedge sysclk); evt[3] = 16'h0808;
        @(negedge sysclk); evt = '0;
        for (int i = 0; i < 5; i++) begin
            rdb = 1'b0; addr = seq[i]; exp_q.push_back(val[seq[i]]);
            @(negedge sysclk);
        end
        rdb = 1'b1;
        // strobe held low for several cycles: repeated identical writes
        wrb = 1'b0; addr = 2'd0; din = 16'h5A5A;
        repeat (3) @(negedge sysclk);
        wrb = 1'b1;
        checks++;
        if (reg_q[0] !== 16'h5A5A || reg_q[1] !== 16'h2222) begin
            failures++;
            $display("FAIL held_write: reg0=%h reg1=%h expected 5a5a 2222", reg_q[0], reg_q[1]);
        end
        wr(2'd3, 16'hFFFF);
    endtask

    task automatic test_out_of_range();
        @(negedge sysclk); wrb3 = 1'b0; addr3 = 2'd0; din3 = 16'hCAFE;
        @(negedge sysclk); wrb3 = 1'b1;
        checks++;
        if (reg_q3[0] !== 16'hCAFE || addr_err3 !== 1'b0) begin
            failures++;
            $display("FAIL oor_inrange_write: reg0=%h err=%b expected cafe 0", reg_q3[0], addr_err3);
        end
        @(negedge sysclk); wrb3 = 1'b0; addr3 = 2'd3; din3 = 16'hFFFF;
        @(negedge sysclk); wrb3 = 1'b1;
        checks++;
        if (reg_q3 !== {16'h0, 16'h0, 16'hCAFE} || addr_err3 !== 1'b1) begin
            failures++;
            $display("FAIL oor_write: reg_q=%h err=%b expected 00000000cafe 1", reg_q3, addr_err3);
        end
        @(negedge sysclk);
        checks++;
        if (addr_err3 !== 1'b0) begin
            failures++;
            $display("FAIL oor_err_pulse: err=%b expected 0", addr_err3);
        end
        rdb3 = 1'b0; addr3 = 2'd0; exp_q3.push_back(16'hCAFE);
        @(negedge sysclk); rdb3 = 1'b0; addr3 = 2'd3; exp_q3.push_back(16'h0000);
        @(negedge sysclk); rdb3 = 1'b1;
        checks++;
        if (addr_err3 !== 1'b1 || rvalid3 !== 1'b1) begin
            failures++;
            $display("FAIL oor_read: err=%b rvalid=%b expected 1 1", addr_err3, rvalid3);
        end
        @(negedge sysclk);
        checks++;
        if (addr_err3 !== 1'b0) begin
            failures++;
            $display("FAIL oor_read_pulse: err=%b expected 0", addr_err3);
        end
    endtask

`ifdef GEN_REGBANK_LOCK_EN
    task automatic test_lock();
        lock = 1'b1;
        wr(2'd0, 16'h0BAD);
        checks++;
        if (reg_q[0] !== 16'h5A5A || addr_err !== 1'b1) begin
            failures++;
            $display("FAIL lock_block: reg0=%h err=%b expected 5a5a 1", reg_q[0], addr_err);
        end
        @(negedge sysclk); evt[3] = 16'h0100;
        @(negedge sysclk); evt = '0;
        wr(2'd3, 16'h0100);
        checks++;
        if (reg_q[3] !== 16'h0 || addr_err !== 1'b0) begin
            failures++;
            $display("FAIL lock_w1c: reg3=%h err=%b expected 0000 0", reg_q[3], addr_err);
        end
        rd(2'd0, 16'h5A5A);
        lock = 1'b0;
    endtask
`endif

    task automatic test_reset_abort();
        @(negedge sysclk); wrb = 1'b0; rdb = 1'b0; addr = 2'd1; din = 16'h1111;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (reg_q !== 64'h0 || rdout !== 16'h0 || rvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort: reg_q=%h rdout=%h rvalid=%b expected 0", reg_q, rdout, rvalid);
        end
        @(negedge sysclk); wrb = 1'b1; rdb = 1'b1;
        @(negedge sysclk); reset = 1'b1;
        @(negedge sysclk);
        checks++;
        if (reg_q !== 64'h0 || rvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort_after: reg_q=%h rvalid=%b expected 0", reg_q, rvalid);
        end
    endtask

    initial begin
        test_reset();
        test_rw();
        test_w1c();
        test_set_wins();
        test_rw_collision();
        test_back_to_back();
        test_out_of_range();
`ifdef GEN_REGBANK_LOCK_EN
        test_lock();
`endif
        repeat (3) @(negedge sysclk);
        checks++;
        if (exp_q.size() != 0 || exp_q3.size() != 0) begin
            failures++;
            $display("FAIL rd_drain: pending=%0d/%0d expected 0/0", exp_q.size(), exp_q3.size());
        end
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
